// File: rtl/period_meter.sv
// Multi-channel period and edge-count meter. Every channel synchronises its
// asynchronous input into the Clk domain and detects the selected edge type.
// It reports the Clk-cycle distance between consecutive qualified edges and
// keeps a wrapping edge tally. All state is clocked by Clk only.
module period_meter #(
  parameter int unsigned CH          = 2,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Clr,
  input  logic [1:0]            Mode,
  input  logic [CH-1:0]         Cin,
  output logic [CH*CNT_W-1:0]   T,
  output logic [CH-1:0]         T_vld,
  output logic [CH-1:0]         Ovf,
  output logic [CH*CNT_W-1:0]   M
);

  typedef enum logic [1:0] {
    EDGE_RISE     = 2'b00,
    EDGE_FALL     = 2'b01,
    EDGE_BOTH     = 2'b10,
    EDGE_RISE_ALT = 2'b11
  } edge_mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CH-1:0]                  prev_q, prev_d;
  logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [CH-1:0][CNT_W-1:0]       t_q, t_d;
  logic [CH-1:0][CNT_W-1:0]       m_q, m_d;
  logic [CH-1:0]                  tvld_q, tvld_d;
  logic [CH-1:0]                  ovf_q, ovf_d;
  logic [CH-1:0]                  armed_q, armed_d;
  edge_mode_e                     mode_q, mode_d;

  logic [CH-1:0]                  s_c, rise_c, fall_c, evt_c;
  logic [CH-1:0][CNT_W-1:0]       cnt_inc_c;
  logic                           mode_chg_c;

  // Synchroniser shift, edge detection and edge-type selection
  always_comb begin
    sync_d = sync_q;
    s_c    = '0;
    for (int i = 0; i < int'(CH); i++) begin
      sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], Cin[i]};
      s_c[i]    = sync_q[i][SYNC_STAGES-1];
    end
    prev_d = s_c;
    rise_c = s_c & ~prev_q;
    fall_c = ~s_c & prev_q;
    mode_d = edge_mode_e'(Mode);
    mode_chg_c = (mode_d != mode_q);
    case (mode_d)
      EDGE_FALL: evt_c = fall_c;
      EDGE_BOTH: evt_c = rise_c | fall_c;
      default:   evt_c = rise_c;
    endcase
  end

  // Saturating increment of each period counter
  always_comb begin
    cnt_inc_c = cnt_q;
    for (int i = 0; i < int'(CH); i++) begin
      if (cnt_q[i] != CNT_MAX) begin
        cnt_inc_c[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Per-channel measurement next state: Clr over En over mode change over event
  always_comb begin
    cnt_d   = cnt_q;
    t_d     = t_q;
    m_d     = m_q;
    ovf_d   = ovf_q;
    armed_d = armed_q;
    tvld_d  = '0;
    for (int i = 0; i < int'(CH); i++) begin
      if (Clr) begin
        cnt_d[i]   = '0;
        t_d[i]     = '0;
        m_d[i]     = '0;
        ovf_d[i]   = 1'b0;
        armed_d[i] = 1'b0;
      end else if (!En) begin
        armed_d[i] = 1'b0;
      end else begin
        cnt_d[i] = cnt_inc_c[i];
        if (mode_chg_c) begin
          armed_d[i] = 1'b0;
        end else if (evt_c[i]) begin
          cnt_d[i]   = '0;
          m_d[i]     = m_q[i] + CNT_W'(1);
          armed_d[i] = 1'b1;
          if (armed_q[i]) begin
            // cnt+1 when unsaturated, full scale otherwise
            t_d[i]    = cnt_inc_c[i];
            tvld_d[i] = 1'b1;
          end
        end
        if (cnt_d[i] == CNT_MAX) begin
          ovf_d[i] = 1'b1;
        end
      end
    end
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync_q  <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      t_q     <= '0;
      m_q     <= '0;
      tvld_q  <= '0;
      ovf_q   <= '0;
      armed_q <= '0;
      mode_q  <= EDGE_RISE;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      m_q     <= m_d;
      tvld_q  <= tvld_d;
      ovf_q   <= ovf_d;
      armed_q <= armed_d;
      mode_q  <= mode_d;
    end
  end

  assign T     = t_q;
  assign M     = m_q;
  assign T_vld = tvld_q;
  assign Ovf   = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: expected periods are queued as edges are
// driven and popped whenever the DUT raises T_vld on that channel.
module tb_period_meter;

  localparam int unsigned CH    = 2;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SS    = 2;

  logic                Clk;
  logic                Rst;
  logic                En;
  logic                Clr;
  logic [1:0]          Mode;
  logic [CH-1:0]       Cin;
  logic [CH*CNT_W-1:0] T;
  logic [CH-1:0]       T_vld;
  logic [CH-1:0]       Ovf;
  logic [CH*CNT_W-1:0] M;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] mon_exp;
  bit          mon_have;

  period_meter #(.CH(CH), .CNT_W(CNT_W), .SYNC_STAGES(SS)) dut (
    .Clk(Clk), .Rst(Rst), .En(En), .Clr(Clr), .Mode(Mode), .Cin(Cin),
    .T(T), .T_vld(T_vld), .Ovf(Ovf), .M(M)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic logic [31:0] m_of(input int ch);
    return 32'(M[ch*CNT_W +: CNT_W]);
  endfunction

  function automatic logic [31:0] t_of(input int ch);
    return 32'(T[ch*CNT_W +: CNT_W]);
  endfunction

  // Scoreboard: every T_vld pops the channel queue and checks the period
  always @(negedge Clk) begin
    if (!Rst) begin
      for (int ch = 0; ch < int'(CH); ch++) begin
        if (T_vld[ch]) begin
          mon_have = 1'b0;
          if (ch == 0 && q0.size() != 0) begin
            mon_have = 1'b1;
            mon_exp  = q0.pop_front();
          end else if (ch == 1 && q1.size() != 0) begin
            mon_have = 1'b1;
            mon_exp  = q1.pop_front();
          end
          if (mon_have) begin
            check($sformatf("T_ch%0d", ch), t_of(ch), mon_exp);
          end else begin
            checks++;
            assert (mon_have) else begin
              errors++;
              $error("FAIL unexpected_tvld_ch%0d: observed T_vld=1 T=%0d expected T_vld=0", ch, t_of(ch));
            end
          end
        end
      end
    end
  end

  initial begin
    Rst  = 1'b1;
    En   = 1'b0;
    Clr  = 1'b0;
    Mode = 2'b00;
    Cin  = '0;
    tick(2);
    check("rst_T", 32'(T), 32'd0);
    check("rst_M", 32'(M), 32'd0);
    check("rst_tvld", 32'(T_vld), 32'd0);
    check("rst_ovf", 32'(Ovf), 32'd0);
    Rst = 1'b0;
    En  = 1'b1;
    tick(3);

    // Rising edges, ch0 period 10, ch1 period 7, five edges each
    for (int c = 0; c < 50; c++) begin
      Cin[0] = ((c % 10) < 5);
      Cin[1] = (c < 31) && ((c % 7) < 3);
      if (c % 10 == 0 && c > 0 && c < 45) q0.push_back(32'd10);
      if (c % 7 == 0 && c > 0 && c < 31) q1.push_back(32'd7);
      tick();
    end
    tick(4);
    check("sq_q0_drain", 32'(q0.size()), 32'd0);
    check("sq_q1_drain", 32'(q1.size()), 32'd0);
    check("sq_M0", m_of(0), 32'd5);
    check("sq_M1", m_of(1), 32'd5);

    // Both edges, high 3 / low 5, then back to rising mid-run
    Mode = 2'b10;
    tick(3);
    for (int c = 0; c < 40; c++) begin
      Cin[0] = ((c % 8) < 3);
      if (c == 25) Mode = 2'b00;
      if (c < 24 && c > 0 && (c % 8) == 0) q0.push_back(32'd5);
      if (c < 24 && (c % 8) == 3) q0.push_back(32'd3);
      if (c == 32) q0.push_back(32'd8);
      tick();
    end
    tick(4);
    check("both_q0_drain", 32'(q0.size()), 32'd0);
    check("both_M0", m_of(0), 32'd13);
    check("both_M1", m_of(1), 32'd5);

    // Saturation and sticky overflow
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check("clr_T", 32'(T), 32'd0);
    check("clr_M", 32'(M), 32'd0);
    Cin[0] = 1'b1;
    tick(2);
    Cin[0] = 1'b0;
    tick(100);
    check("ovf_early", 32'(Ovf), 32'd0);
    tick(200);
    check("ovf_set", 32'(Ovf), 32'd3);
    q0.push_back(32'd255);
    Cin[0] = 1'b1;
    tick(2);
    Cin[0] = 1'b0;
    tick(4);
    check("ovf_q0_drain", 32'(q0.size()), 32'd0);
    check("ovf_sticky", 32'(Ovf[0]), 32'd1);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check("ovf_clr", 32'(Ovf), 32'd0);
    tick(3);

    // Clr coincident with a qualified edge
    Cin[0] = 1'b1;
    tick(2);
    Cin[0] = 1'b0;
    tick(4);
    check("cc_arm_M0", m_of(0), 32'd1);
    Cin[0] = 1'b1;
    tick(2);
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    check("cc_tvld", 32'(T_vld), 32'd0);
    check("cc_T", 32'(T), 32'd0);
    check("cc_M", 32'(M), 32'd0);
    tick();
    Cin[0] = 1'b0;
    tick(4);
    Cin[0] = 1'b1;
    tick(3);
    Cin[0] = 1'b0;
    tick(4);
    check("cc_rearm_M0", m_of(0), 32'd1);
    q0.push_back(32'd7);
    Cin[0] = 1'b1;
    tick(2);
    check("lat_early", 32'(T_vld[0]), 32'd0);
    tick();
    check("lat_vld", 32'(T_vld[0]), 32'd1);
    check("lat_T0", t_of(0), 32'd7);
    Cin[0] = 1'b0;
    tick(4);
    check("cc_q0_drain", 32'(q0.size()), 32'd0);
    check("cc_M0", m_of(0), 32'd2);

    // 256 edges at period 4 with an En gap: M wraps to 0
    Clr = 1'b1;
    tick();
    Clr = 1'b0;
    tick(2);
    for (int e = 0; e < 256; e++) begin
      if (e == 100) begin
        check("wrap_M_pre_gap", m_of(0), 32'd100);
        En = 1'b0;
        tick(20);
        check("wrap_M_hold", m_of(0), 32'd100);
        En = 1'b1;
      end
      if (e != 0 && e != 100) q0.push_back(32'd4);
      Cin[0] = 1'b1;
      tick(2);
      Cin[0] = 1'b0;
      tick(2);
    end
    tick(4);
    check("wrap_q0_drain", 32'(q0.size()), 32'd0);
    check("wrap_M0", m_of(0), 32'd0);

    // Asynchronous reset mid-count
    q0.push_back(32'd8);
    Cin[0] = 1'b1;
    tick(2);
    Cin[0] = 1'b0;
    tick(4);
    check("pre_rst_M0", m_of(0), 32'd1);
    check("pre_rst_q0_drain", 32'(q0.size()), 32'd0);
    tick(5);
    @(posedge Clk);
    #3;
    Rst = 1'b1;
    #1;
    check("arst_T", 32'(T), 32'd0);
    check("arst_M", 32'(M), 32'd0);
    check("arst_ovf", 32'(Ovf), 32'd0);
    check("arst_tvld", 32'(T_vld), 32'd0);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    q0.delete();
    q1.delete();
    tick(2);
    Cin[0] = 1'b1;
    tick(2);
    Cin[0] = 1'b0;
    tick(4);
    check("post_rst_M0", m_of(0), 32'd1);
    check("post_rst_T", 32'(T), 32'd0);
    check("end_q1_drain", 32'(q1.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
